operand_entry: RTL and testbench

- Front-end input stage that feeds the CPU operand inputs `in1` / `in2`.
- Takes a raw 4-bit switch bank and a raw, bouncing pushbutton, then synchronises and debounces the button.
- Captures two successive operands, holds them stable, and asserts `operands_valid` until the CPU side acknowledges with `consume`.
- Replaces direct wiring of board switches to the CPU, so the CPU always sees clean operand pairs that do not change mid-operation.

---
 rtl/operand_entry.sv | 163 ++++++++++++++++
 tb/tb_operand_entry.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// operand_entry
// Front-end input stage that turns a raw switch bank and a bouncing
// pushbutton into clean, stable operand pairs for the CPU.
//
// Each debounced button press captures the switch bank: the first press
// into in1, the second into in2. The pair is then held with
// operands_valid high until the CPU acknowledges it with consume.
//
// Ports:
//   clock          - system clock, rising edge active
//   reset_n        - asynchronous active-low reset
//   switches       - operand value from the switch bank
//   btn            - raw pushbutton, active-high, asynchronous, may bounce
//   consume        - one-cycle pulse: CPU has taken the current pair
//   clear          - synchronous abort of operand entry
//   in1, in2       - captured operands (registered)
//   operands_valid - high while in1/in2 hold a complete, unconsumed pair
//   entry_state    - FSM state: 00 WAIT_A, 01 WAIT_B, 10 READY
module operand_entry #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switches,
  input  logic             btn,
  input  logic             consume,
  input  logic             clear,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic             operands_valid,
  output logic [1:0]       entry_state
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } entryState_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncMeta_q;
  logic             syncOut_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entryState_t      state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic             valid_q, valid_d;

  logic bS;
  logic cntAtMax;
  logic press;

  assign bS       = syncOut_q;
  assign cntAtMax = (cnt_q == CntMax);

  // A press is the last cycle of a qualifying low-to-high run: stable will
  // rise on this edge, so the event fires exactly once per debounced press.
  assign press = bS && !stable_q && cntAtMax;

  // Two-flop synchroniser bringing the asynchronous button into the clock
  // domain before any decision is made on it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
    end else begin
      syncMeta_q <= btn;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Debounce: the synchronised level must differ from the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles before it is adopted. Any return
  // to the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (bS == stable_q) begin
      cnt_d = '0;
    end else if (cntAtMax) begin
      stable_d = bS;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry FSM, priority clear > consume > press. A press arriving together
  // with clear or consume is simply dropped. The unused encoding recovers
  // to WAIT_A with valid low.
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    valid_d = valid_q;
    if (clear) begin
      in1_d   = '0;
      in2_d   = '0;
      valid_d = 1'b0;
      state_d = WAIT_A;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (press) begin
            in1_d   = switches;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (press) begin
            in2_d   = switches;
            valid_d = 1'b1;
            state_d = READY;
          end
        end
        READY: begin
          if (consume) begin
            valid_d = 1'b0;
            state_d = WAIT_A;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = WAIT_A;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_A;
      in1_q   <= '0;
      in2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      valid_q <= valid_d;
    end
  end

  assign in1            = in1_q;
  assign in2            = in2_q;
  assign operands_valid = valid_q;
  assign entry_state    = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry
// Directed testbench for operand_entry. Inputs are driven and outputs are
// sampled on the falling clock edge; cycles(n) advances to the falling edge
// that follows the n-th rising edge, so "edge k" below counts rising edges
// after the stimulus change.
module tb_operand_entry;

  logic       clock;
  logic       reset_n;
  logic [3:0] switches;
  logic       btn;
  logic       consume;
  logic       clear;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       operands_valid;
  logic [1:0] entry_state;

  int total = 0;
  int bad   = 0;

  operand_entry #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .switches(switches),
    .btn(btn),
    .consume(consume),
    .clear(clear),
    .in1(in1),
    .in2(in2),
    .operands_valid(operands_valid),
    .entry_state(entry_state)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the falling edge after n rising edges.
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Power-on reset: all outputs must be zero while reset is held.
  task automatic test_reset_initial;
    reset_n = 1'b0; btn = 1'b0; switches = 4'd0; consume = 1'b0; clear = 1'b0;
    #1;
    total++; if (in1 !== 4'd0) begin bad++; $display("[TB] FAIL por_in1 got=%0d exp=0", in1); end
    total++; if (in2 !== 4'd0) begin bad++; $display("[TB] FAIL por_in2 got=%0d exp=0", in2); end
    total++; if (operands_valid !== 1'b0) begin bad++; $display("[TB] FAIL por_valid got=%0b exp=0", operands_valid); end
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL por_state got=%0b exp=00", entry_state); end
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
  endtask

  // Two clean presses capture 3 then 5; capture happens on edge 6, not 5,
  // and holding the button yields only a single press.
  task automatic test_clean_entry;
    switches = 4'd3; btn = 1'b1;
    cycles(5);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL clean_early_state got=%0b exp=00", entry_state); end
    total++; if (in1 !== 4'd0) begin bad++; $display("[TB] FAIL clean_early_in1 got=%0d exp=0", in1); end
    cycles(1);
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL clean_in1 got=%0d exp=3", in1); end
    total++; if (entry_state !== 2'b01) begin bad++; $display("[TB] FAIL clean_stateB got=%0b exp=01", entry_state); end
    cycles(2);
    total++; if (entry_state !== 2'b01) begin bad++; $display("[TB] FAIL clean_hold_once got=%0b exp=01", entry_state); end
    btn = 1'b0;
    cycles(8);
    switches = 4'd5; btn = 1'b1;
    cycles(5);
    total++; if (operands_valid !== 1'b0) begin bad++; $display("[TB] FAIL clean_early_valid got=%0b exp=0", operands_valid); end
    cycles(1);
    total++; if (in2 !== 4'd5) begin bad++; $display("[TB] FAIL clean_in2 got=%0d exp=5", in2); end
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL clean_in1_held got=%0d exp=3", in1); end
    total++; if (operands_valid !== 1'b1) begin bad++; $display("[TB] FAIL clean_valid got=%0b exp=1", operands_valid); end
    total++; if (entry_state !== 2'b10) begin bad++; $display("[TB] FAIL clean_ready got=%0b exp=10", entry_state); end
    cycles(2);
    btn = 1'b0;
    cycles(8);
  endtask

  // In READY a new press is ignored; consume returns to WAIT_A while the
  // captured operands stay visible.
  task automatic test_ready_hold;
    switches = 4'd9; btn = 1'b1;
    cycles(8);
    btn = 1'b0;
    cycles(8);
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL ready_in1 got=%0d exp=3", in1); end
    total++; if (in2 !== 4'd5) begin bad++; $display("[TB] FAIL ready_in2 got=%0d exp=5", in2); end
    total++; if (entry_state !== 2'b10) begin bad++; $display("[TB] FAIL ready_state got=%0b exp=10", entry_state); end
    total++; if (operands_valid !== 1'b1) begin bad++; $display("[TB] FAIL ready_valid got=%0b exp=1", operands_valid); end
    consume = 1'b1;
    cycles(1);
    consume = 1'b0;
    total++; if (operands_valid !== 1'b0) begin bad++; $display("[TB] FAIL consume_valid got=%0b exp=0", operands_valid); end
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL consume_state got=%0b exp=00", entry_state); end
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL consume_in1 got=%0d exp=3", in1); end
    total++; if (in2 !== 4'd5) begin bad++; $display("[TB] FAIL consume_in2 got=%0d exp=5", in2); end
  endtask

  // Short bursts never reach the debounce threshold.
  task automatic test_bounce;
    switches = 4'd12;
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(1);
    btn = 1'b0;
    cycles(8);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL bounce_state got=%0b exp=00", entry_state); end
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL bounce_in1 got=%0d exp=3", in1); end
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    cycles(8);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL short_state got=%0b exp=00", entry_state); end
    total++; if (in1 !== 4'd3) begin bad++; $display("[TB] FAIL short_in1 got=%0d exp=3", in1); end
  endtask

  // Clear wins over a simultaneous press; consume outside READY does nothing.
  task automatic test_clear_priority;
    switches = 4'd7; btn = 1'b1;
    cycles(8);
    btn = 1'b0;
    cycles(8);
    total++; if (in1 !== 4'd7) begin bad++; $display("[TB] FAIL clr_setup_in1 got=%0d exp=7", in1); end
    consume = 1'b1;
    cycles(1);
    consume = 1'b0;
    total++; if (entry_state !== 2'b01) begin bad++; $display("[TB] FAIL consume_in_B got=%0b exp=01", entry_state); end
    switches = 4'd11; btn = 1'b1;
    cycles(5);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    total++; if (in1 !== 4'd0) begin bad++; $display("[TB] FAIL clr_in1 got=%0d exp=0", in1); end
    total++; if (in2 !== 4'd0) begin bad++; $display("[TB] FAIL clr_in2 got=%0d exp=0", in2); end
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL clr_state got=%0b exp=00", entry_state); end
    total++; if (operands_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_valid got=%0b exp=0", operands_valid); end
    cycles(4);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL clr_no_repress got=%0b exp=00", entry_state); end
    btn = 1'b0;
    cycles(8);
  endtask

  // Asynchronous reset mid-cycle clears outputs at once; after release with
  // the button still high, the press lands on edge 6.
  task automatic test_reset_async;
    switches = 4'd6; btn = 1'b1;
    cycles(8);
    total++; if (in1 !== 4'd6) begin bad++; $display("[TB] FAIL rst_setup_in1 got=%0d exp=6", in1); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (in1 !== 4'd0) begin bad++; $display("[TB] FAIL rst_in1 got=%0d exp=0", in1); end
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL rst_state got=%0b exp=00", entry_state); end
    total++; if (operands_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b exp=0", operands_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    cycles(5);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL rst_early_state got=%0b exp=00", entry_state); end
    cycles(1);
    total++; if (entry_state !== 2'b01) begin bad++; $display("[TB] FAIL rst_press_state got=%0b exp=01", entry_state); end
    total++; if (in1 !== 4'd6) begin bad++; $display("[TB] FAIL rst_press_in1 got=%0d exp=6", in1); end
    btn = 1'b0;
    cycles(8);
  endtask

  // Reset during a partially counted press restarts the debounce count.
  task automatic test_reset_mid_debounce;
    switches = 4'd10; btn = 1'b1;
    cycles(3);
    #2 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cycles(5);
    total++; if (entry_state !== 2'b00) begin bad++; $display("[TB] FAIL mid_early_state got=%0b exp=00", entry_state); end
    total++; if (in1 !== 4'd0) begin bad++; $display("[TB] FAIL mid_early_in1 got=%0d exp=0", in1); end
    cycles(1);
    total++; if (in1 !== 4'd10) begin bad++; $display("[TB] FAIL mid_in1 got=%0d exp=10", in1); end
    total++; if (entry_state !== 2'b01) begin bad++; $display("[TB] FAIL mid_state got=%0b exp=01", entry_state); end
    btn = 1'b0;
    cycles(8);
  endtask

  initial begin
    test_reset_initial();
    test_clean_entry();
    test_ready_hold();
    test_bounce();
    test_clear_priority();
    test_reset_async();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
